// File: rtl/cmd_frame_sequencer.sv
// Command frame sequencer: decodes UART command frames, drives register-file
// and ALU strobes, and queues response bytes into the TX FIFO.
module cmd_frame_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUN_WIDTH  = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
   input  logic                      RX_D_VLD,
   output logic                      WrEn,
   output logic                      RdEn,
   output logic [ADDR_WIDTH-1:0]     Address,
   output logic [DATA_WIDTH-1:0]     WrData,
   input  logic [DATA_WIDTH-1:0]     RdData,
   input  logic                      RdData_Valid,
   output logic                      ALU_EN,
   output logic [FUN_WIDTH-1:0]      ALU_FUN,
   output logic                      CLK_GATE_EN,
   input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
   input  logic                      ALU_OUT_VLD,
   input  logic                      FIFO_FULL,
   output logic [DATA_WIDTH-1:0]     TX_P_DATA,
   output logic                      TX_D_VLD,
   output logic                      CMD_ERR
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [DATA_WIDTH-1:0] CMD_WR     = 8'hAA;
   localparam logic [DATA_WIDTH-1:0] CMD_RD     = 8'hBB;
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = 8'hCC;
   localparam logic [DATA_WIDTH-1:0] CMD_ALU    = 8'hDD;

   localparam logic [ADDR_WIDTH-1:0] ADDR_OP_A = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_OP_B = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_WR_ADDR  = 4'd1;
   localparam logic [3:0] S_WR_DATA  = 4'd2;
   localparam logic [3:0] S_RD_ADDR  = 4'd3;
   localparam logic [3:0] S_RD_WAIT  = 4'd4;
   localparam logic [3:0] S_OP_A     = 4'd5;
   localparam logic [3:0] S_OP_B     = 4'd6;
   localparam logic [3:0] S_FUN      = 4'd7;
   localparam logic [3:0] S_ALU_WAIT = 4'd8;
   localparam logic [3:0] S_TX_RD    = 4'd9;
   localparam logic [3:0] S_TX_LO    = 4'd10;
   localparam logic [3:0] S_TX_HI    = 4'd11;

   logic [3:0]              state_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [DATA_WIDTH-1:0]   rd_data_r;
   logic [2*DATA_WIDTH-1:0] alu_res_r;
   logic [CNT_W-1:0]        cnt_r;

   // Frame FSM with registered outputs; strobes default low every cycle.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r     <= S_IDLE;
         addr_r      <= {ADDR_WIDTH{1'b0}};
         rd_data_r   <= {DATA_WIDTH{1'b0}};
         alu_res_r   <= {(2*DATA_WIDTH){1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         WrEn        <= 1'b0;
         RdEn        <= 1'b0;
         ALU_EN      <= 1'b0;
         TX_D_VLD    <= 1'b0;
         CMD_ERR     <= 1'b0;
         CLK_GATE_EN <= 1'b0;
         Address     <= {ADDR_WIDTH{1'b0}};
         WrData      <= {DATA_WIDTH{1'b0}};
         ALU_FUN     <= {FUN_WIDTH{1'b0}};
         TX_P_DATA   <= {DATA_WIDTH{1'b0}};
      end else begin
         WrEn     <= 1'b0;
         RdEn     <= 1'b0;
         ALU_EN   <= 1'b0;
         TX_D_VLD <= 1'b0;
         CMD_ERR  <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (RX_D_VLD) begin
                  case (RX_P_DATA)
                     CMD_WR:     state_r <= S_WR_ADDR;
                     CMD_RD:     state_r <= S_RD_ADDR;
                     CMD_ALU_OP: state_r <= S_OP_A;
                     CMD_ALU:    state_r <= S_FUN;
                     default:    CMD_ERR <= 1'b1;
                  endcase
               end
            end
            S_WR_ADDR: begin
               if (RX_D_VLD) begin
                  addr_r  <= RX_P_DATA[ADDR_WIDTH-1:0];
                  state_r <= S_WR_DATA;
               end
            end
            S_WR_DATA: begin
               if (RX_D_VLD) begin
                  WrEn    <= 1'b1;
                  Address <= addr_r;
                  WrData  <= RX_P_DATA;
                  state_r <= S_IDLE;
               end
            end
            S_RD_ADDR: begin
               if (RX_D_VLD) begin
                  RdEn    <= 1'b1;
                  Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                  cnt_r   <= {CNT_W{1'b0}};
                  state_r <= S_RD_WAIT;
               end
            end
            // A valid on the expiry edge is checked first so it wins over the timeout.
            S_RD_WAIT: begin
               if (RdData_Valid) begin
                  rd_data_r <= RdData;
                  state_r   <= S_TX_RD;
               end else if (cnt_r == CNT_LAST) begin
                  CMD_ERR <= 1'b1;
                  state_r <= S_IDLE;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            S_OP_A: begin
               if (RX_D_VLD) begin
                  WrEn    <= 1'b1;
                  Address <= ADDR_OP_A;
                  WrData  <= RX_P_DATA;
                  state_r <= S_OP_B;
               end
            end
            S_OP_B: begin
               if (RX_D_VLD) begin
                  WrEn    <= 1'b1;
                  Address <= ADDR_OP_B;
                  WrData  <= RX_P_DATA;
                  state_r <= S_FUN;
               end
            end
            S_FUN: begin
               if (RX_D_VLD) begin
                  ALU_FUN     <= RX_P_DATA[FUN_WIDTH-1:0];
                  CLK_GATE_EN <= 1'b1;
                  ALU_EN      <= 1'b1;
                  cnt_r       <= {CNT_W{1'b0}};
                  state_r     <= S_ALU_WAIT;
               end
            end
            S_ALU_WAIT: begin
               if (ALU_OUT_VLD) begin
                  alu_res_r <= ALU_OUT;
                  state_r   <= S_TX_LO;
               end else if (cnt_r == CNT_LAST) begin
                  CMD_ERR     <= 1'b1;
                  CLK_GATE_EN <= 1'b0;
                  state_r     <= S_IDLE;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            S_TX_RD: begin
               if (!FIFO_FULL) begin
                  TX_D_VLD  <= 1'b1;
                  TX_P_DATA <= rd_data_r;
                  state_r   <= S_IDLE;
               end
            end
            S_TX_LO: begin
               if (!FIFO_FULL) begin
                  TX_D_VLD  <= 1'b1;
                  TX_P_DATA <= alu_res_r[DATA_WIDTH-1:0];
                  state_r   <= S_TX_HI;
               end
            end
            S_TX_HI: begin
               if (!FIFO_FULL) begin
                  TX_D_VLD    <= 1'b1;
                  TX_P_DATA   <= alu_res_r[2*DATA_WIDTH-1:DATA_WIDTH];
                  CLK_GATE_EN <= 1'b0;
                  state_r     <= S_IDLE;
               end
            end
            default: state_r <= S_IDLE;
         endcase
      end
   end

endmodule
